// File: rtl/branch_resolve_bht_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_bht_if
// Groups the fetch-lookup and EX-resolution signals of branch_resolve_bht.
//   master : pipeline side. Drives lookup PC and EX instruction fields,
//            receives prediction, pcsrc, redirect, exceptions and statistics.
//   slave  : branch_resolve_bht side (opposite directions).
// -----------------------------------------------------------------------------
interface branch_resolve_bht_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    // fetch lookup
    logic [XLEN-1:0]  lu_pc;
    logic             lu_pred_taken;

    // EX stage instruction
    logic             ex_valid;
    logic             ex_branch;
    logic             ex_jalr;
    logic [2:0]       ex_func3;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_rs1;
    logic             ex_pred_taken;
    logic             ex_zf;
    logic             ex_lt;
    logic             ex_ltu;

    // resolution results
    logic             pcsrc;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             misalign_exc;
    logic             illegal_br;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output lu_pc,
        output ex_valid, ex_branch, ex_jalr, ex_func3, ex_pc, ex_imm, ex_rs1,
        output ex_pred_taken, ex_zf, ex_lt, ex_ltu,
        input  lu_pred_taken, pcsrc, redirect_valid, redirect_pc,
        input  misalign_exc, illegal_br, branch_count, mispredict_count
    );

    modport slave (
        input  lu_pc,
        input  ex_valid, ex_branch, ex_jalr, ex_func3, ex_pc, ex_imm, ex_rs1,
        input  ex_pred_taken, ex_zf, ex_lt, ex_ltu,
        output lu_pred_taken, pcsrc, redirect_valid, redirect_pc,
        output misalign_exc, illegal_br, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// branch_resolve_bht
// EX-stage branch resolution for RV32I with a bimodal branch history table.
// Resolves the six conditional branches and JALR from ALU flags, compares the
// outcome with the fetch-time prediction and issues a registered one-cycle
// redirect (or misalign / illegal-funct3 pulse). Fetch reads the BHT through
// a combinational lookup port.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : branch_resolve_bht_if.slave (lookup, EX inputs, results, stats)
// -----------------------------------------------------------------------------
module branch_resolve_bht #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter int         INDEX_LSB   = 2,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    parameter int         CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    branch_resolve_bht_if.slave      bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // state
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             misalign_exc_q, misalign_exc_d;
    logic             illegal_br_q, illegal_br_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    // resolution datapath
    logic             qual;
    logic             cond;
    logic             func3_legal;
    logic             is_jalr;
    logic             is_br;
    logic             br_legal;
    logic             actual_taken;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  jalr_target;
    logic [XLEN-1:0]  fall_through;
    logic [XLEN-1:0]  taken_target;
    logic             misalign;
    logic             need_redirect;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] lu_idx;

    assign lu_idx = bus.lu_pc[INDEX_LSB +: IDX_W];
    assign wr_idx = bus.ex_pc[INDEX_LSB +: IDX_W];

    // Remaining lookup-PC bits and the discarded JALR LSB carry no information here.
    logic unused_bits;
    assign unused_bits = ^{bus.lu_pc, jalr_sum[0]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cond        = 1'b0;
        func3_legal = 1'b1;
        case (bus.ex_func3)
            3'b000:  cond = bus.ex_zf;
            3'b001:  cond = ~bus.ex_zf;
            3'b100:  cond = bus.ex_lt;
            3'b101:  cond = ~bus.ex_lt;
            3'b110:  cond = bus.ex_ltu;
            3'b111:  cond = ~bus.ex_ltu;
            default: func3_legal = 1'b0;   // 010 / 011
        endcase

        // The instruction in EX during a redirect cycle is on the wrong path.
        qual         = bus.ex_valid & ~redirect_valid_q;
        is_jalr      = qual & bus.ex_jalr;
        is_br        = qual & bus.ex_branch & ~bus.ex_jalr;   // JALR wins when both set
        br_legal     = is_br & func3_legal;
        actual_taken = is_jalr | (br_legal & cond);

        br_target    = bus.ex_pc + bus.ex_imm;
        jalr_sum     = bus.ex_rs1 + bus.ex_imm;
        jalr_target  = {jalr_sum[XLEN-1:1], 1'b0};
        fall_through = bus.ex_pc + XLEN'(4);
        taken_target = bus.ex_jalr ? jalr_target : br_target;

        // A taken target that is not 4-byte aligned raises an exception instead of redirecting.
        misalign      = actual_taken & taken_target[1];
        need_redirect = (is_jalr | (br_legal & (actual_taken != bus.ex_pred_taken))) & ~misalign;

        redirect_valid_d = need_redirect;
        misalign_exc_d   = misalign;
        illegal_br_d     = is_br & ~func3_legal;
        redirect_pc_d    = redirect_pc_q;
        if (need_redirect || misalign) begin
            redirect_pc_d = actual_taken ? taken_target : fall_through;
        end

        branch_count_d = branch_count_q;
        if (br_legal && (branch_count_q != {CNT_W{1'b1}})) begin
            branch_count_d = branch_count_q + CNT_W'(1);
        end
        mispredict_count_d = mispredict_count_q;
        if (need_redirect && (mispredict_count_q != {CNT_W{1'b1}})) begin
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end

        // Saturating 2-bit counter update at the resolving branch's index.
        bht_d = bht_q;
        if (br_legal) begin
            if (actual_taken) begin
                if (bht_q[wr_idx] != 2'b11) bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
            end else begin
                if (bht_q[wr_idx] != 2'b00) bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the table is kept in flops rather than RAM so every entry can be reset to CTR_INIT.
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CTR_INIT;
            end
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            misalign_exc_q     <= 1'b0;
            illegal_br_q       <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            bht_q              <= bht_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            misalign_exc_q     <= misalign_exc_d;
            illegal_br_q       <= illegal_br_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Lookup reads the registered table only: a same-cycle write is not bypassed.
    assign bus.lu_pred_taken    = bht_q[lu_idx][1];
    assign bus.pcsrc            = actual_taken;
    assign bus.redirect_valid   = redirect_valid_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.misalign_exc     = misalign_exc_q;
    assign bus.illegal_br       = illegal_br_q;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_resolve_bht.md
# branch_resolve_bht

Parametrised branch resolution unit with a bimodal branch history table (BHT). It sits at the EX stage of the RV32I pipeline and resolves all six conditional branches plus JALR from ALU flags. It checks each outcome against the prediction carried down the pipe and issues a registered one-cycle redirect/flush on mispredict. The fetch stage reads direction predictions from the BHT through a lookup port. Mispredict and branch statistics are kept in saturating counters.

## Interface
- XLEN, 32, datapath width.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, ≥2; IDX_W = log2(BHT_ENTRIES).
- INDEX_LSB, 2, lowest PC bit used for the BHT index.
- CTR_INIT, 2'b01, counter reset value (weakly not-taken).
- CNT_W, 32, statistics counter width.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- lu_pc  in  XLEN  fetch lookup PC.
- lu_pred_taken  out  1  counter[lu_pc index] bit 1; combinational read of registered table.
- ex_valid  in  1  EX holds a valid instruction.
- ex_branch  in  1  conditional branch in EX.
- ex_jalr  in  1  JALR in EX.
- ex_func3  in  3  branch funct3.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_rs1  in  XLEN  rs1 value (JALR base).
- ex_pred_taken  in  1  prediction made at fetch for this instruction.
- ex_zf, ex_lt, ex_ltu  in  1 each  ALU rs1−rs2 flags: equal, signed less-than, unsigned less-than.
- pcsrc  out  1  combinational actual-taken for the qualified EX instruction.
- redirect_valid  out  1  registered one-cycle redirect/flush pulse.
- redirect_pc  out  XLEN  registered redirect target.
- misalign_exc  out  1  registered one-cycle instruction-address-misaligned pulse.
- illegal_br  out  1  registered one-cycle illegal-funct3 pulse.
- branch_count  out  CNT_W  resolved conditional branches.
- mispredict_count  out  CNT_W  redirects issued.

## Operation
- Qualified EX: q = ex_valid & ~redirect_valid. The wrong-path instruction in EX during a redirect cycle is squashed and has no effect.
- Conditions by ex_func3:
  - 000: taken when zf.
  - 001: taken when ~zf.
  - 100: taken when lt.
  - 101: taken when ~lt.
  - 110: taken when ltu.
  - 111: taken when ~ltu.
  - 010/011: illegal. Branch is not taken, no BHT update, no count, and illegal_br pulses.
- Taken value: pcsrc = q & ((ex_branch & cond) | ex_jalr). If ex_branch and ex_jalr are both set, ex_jalr wins.
- Targets:
  - Branch: ex_pc + ex_imm.
  - JALR: (ex_rs1 + ex_imm) & ~1.
  - Fall-through: ex_pc + 4.
  - All arithmetic is modulo 2^XLEN.
- Redirect rules:
  - Legal branch: redirect when actual ≠ ex_pred_taken. Target is the branch target if actual is taken, otherwise fall-through.
  - JALR: always redirects.
  - Misaligned: if the taken target has bit 1 set, no redirect is issued and misalign_exc pulses instead.
- BHT update: for a qualified legal branch, index = ex_pc[INDEX_LSB +: IDX_W]. The counter increments when taken and decrements when not taken, saturating at 3 and 0. JALR does not update the BHT.
- Statistics:
  - branch_count increments per qualified legal branch.
  - mispredict_count increments per redirect_valid pulse.
  - Both counters saturate at all-ones.
- Reset, while rst_n = 0 at an edge:
  - All BHT counters load CTR_INIT.
  - redirect_valid, misalign_exc, illegal_br and both counters load 0.
  - redirect_pc loads 0.
  - A resolution in flight during reset is discarded.

## Timing
- Resolution sampled at edge N. redirect_valid, redirect_pc and the exception pulses are high during cycle N+1, for exactly one cycle.
- BHT write happens at edge N. A lookup in cycle N+1 sees the new value. A same-cycle lookup at the index being written returns the old value (no bypass).
- pcsrc has zero latency, for compatibility with the existing PC mux.
- A qualified instruction in EX during cycle N+1 is squashed.
- Back-to-back correctly predicted branches resolve every cycle.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles → all outputs 0; lu_pred_taken = 0 for every index (CTR_INIT = 01).
- BEQ mispredict: ex_pc = 0x100, imm = 0x40, zf = 1, pred = 0 → pcsrc = 1; next cycle redirect_valid = 1, redirect_pc = 0x140, mispredict_count = 1, branch_count = 1; counter goes 01→10, so lu_pc = 0x100 then predicts taken.
- BLTU not taken, correctly predicted: ltu = 0, pred = 0 → no redirect; counter saturates at 00 after repeats; branch_count increments each time.
- Squash: redirect in cycle N+1 while ex_valid = 1 with a taken BNE → no second redirect, no BHT or count change.
- JALR: rs1 = 0x2003, imm = 0 → redirect_pc = 0x2002 triggers misalign_exc with no redirect; with rs1 = 0x2001 → redirect_pc = 0x2000.
- func3 = 010 → illegal_br pulses; pcsrc = 0; counts unchanged. Reset asserted during a redirect cycle → outputs cleared at the next edge.
